// File: rtl/tcp_to_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcp_to_bus_pkg
// Description : Shared parser states and header size for the SiTCP-to-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package tcp_to_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN1  = 3'd1,
    ST_ADDR0 = 3'd2,
    ST_ADDR1 = 3'd3,
    ST_ADDR2 = 3'd4,
    ST_ADDR3 = 3'd5,
    ST_DATA  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  localparam logic [15:0] HEADER_BYTES = 16'd6;

endpackage
`default_nettype wire

// File: rtl/tcp_to_bus.sv
`default_nettype none
// ============================================================================
// Module      : tcp_to_bus
// Description : Parses SiTCP byte stream packets (LEN, ADDR, data) into bus writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_to_bus #(
  parameter int ABUSWIDTH = 32
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_n,
  input  logic                 TCP_OPEN_ACK,
  input  logic                 TCP_RX_WR,
  input  logic [7:0]           TCP_RX_DATA,
  output logic [15:0]          TCP_RX_WC,
  output logic                 BUS_WR,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  output logic [7:0]           BUS_DATA,
  output logic                 ACTIVE,
  output logic                 ERROR
);

  import tcp_to_bus_pkg::*;

  state_t               r_state;
  logic [15:0]          r_len;
  logic [15:0]          r_count;
  logic [23:0]          r_addr_lo;
  logic [ABUSWIDTH-1:0] r_addr;

  // Every byte is consumed in the cycle it arrives, so the receive window never shrinks.
  assign TCP_RX_WC = 16'hFFFF;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_n) begin
    if (!BUS_RST_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_count   <= '0;
      r_addr_lo <= '0;
      r_addr    <= '0;
      BUS_WR    <= 1'b0;
      BUS_ADD   <= '0;
      BUS_DATA  <= '0;
      ACTIVE    <= 1'b0;
      ERROR     <= 1'b0;
    end else begin
      BUS_WR <= 1'b0;
      if (!TCP_OPEN_ACK) begin
        r_state <= ST_IDLE;
        ACTIVE  <= 1'b0;
      end else if (TCP_RX_WR) begin
        case (r_state)
          ST_IDLE: begin
            r_len[7:0] <= TCP_RX_DATA;
            r_state    <= ST_LEN1;
            ACTIVE     <= 1'b1;
          end
          ST_LEN1: begin
            r_len[15:8] <= TCP_RX_DATA;
            r_state     <= ST_ADDR0;
          end
          ST_ADDR0: begin
            r_addr_lo[7:0] <= TCP_RX_DATA;
            r_state        <= ST_ADDR1;
          end
          ST_ADDR1: begin
            r_addr_lo[15:8] <= TCP_RX_DATA;
            r_state         <= ST_ADDR2;
          end
          ST_ADDR2: begin
            r_addr_lo[23:16] <= TCP_RX_DATA;
            r_state          <= ST_ADDR3;
          end
          ST_ADDR3: begin
            r_addr  <= ABUSWIDTH'({TCP_RX_DATA, r_addr_lo});
            r_count <= r_len - HEADER_BYTES;
            if (r_len < HEADER_BYTES) begin
              r_state <= ST_ERR;
              ERROR   <= 1'b1;
            end else if (r_len == HEADER_BYTES) begin
              r_state <= ST_IDLE;
              ACTIVE  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            BUS_WR   <= 1'b1;
            BUS_DATA <= TCP_RX_DATA;
            BUS_ADD  <= r_addr;
            r_addr   <= r_addr + ABUSWIDTH'(1);
            r_count  <= r_count - 16'd1;
            if (r_count == 16'd1) begin
              r_state <= ST_IDLE;
              ACTIVE  <= 1'b0;
            end
          end
          // A malformed length locks the parser until the connection drops.
          ST_ERR: r_state <= ST_ERR;
          default: begin
            r_state <= ST_IDLE;
            ACTIVE  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcp_to_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcp_to_bus
// Description : Directed-vector bench for the SiTCP packet-to-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_to_bus;

  import tcp_to_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic        rx_wr = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [15:0] rx_wc;
  logic        bus_wr;
  logic [31:0] bus_add;
  logic [7:0]  bus_data;
  logic        active;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int base;

  tcp_to_bus #(.ABUSWIDTH(32)) dut (
    .BUS_CLK     (clk),
    .BUS_RST_n   (rst_n),
    .TCP_OPEN_ACK(ack),
    .TCP_RX_WR   (rx_wr),
    .TCP_RX_DATA (rx_data),
    .TCP_RX_WC   (rx_wc),
    .BUS_WR      (bus_wr),
    .BUS_ADD     (bus_add),
    .BUS_DATA    (bus_data),
    .ACTIVE      (active),
    .ERROR       (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_wr === 1'b1) wr_count++;

  task automatic step(input logic wr, input logic [7:0] d, input logic a);
    @(negedge clk);
    rx_wr = wr; rx_data = d; ack = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++; if (bus_wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", bus_wr); end
    vectors++; if (bus_add !== 32'h0) begin miscompares++; $display("FAIL reset_add: got %h want 0", bus_add); end
    vectors++; if (bus_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", bus_data); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b want 0", active); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", error); end
    vectors++; if (rx_wc !== 16'hFFFF) begin miscompares++; $display("FAIL reset_wc: got %h want ffff", rx_wc); end
    @(negedge clk); rst_n = 1'b1; ack = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    base = wr_count;
    step(1, 8'h08, 1); step(1, 8'h00, 1);
    vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL basic_active_hdr: got %b want 1", active); end
    step(1, 8'h00, 1); step(1, 8'h10, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'hAA, 1); step(1, 8'hBB, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h1000, 8'hAA})
      begin miscompares++; $display("FAIL basic_w0: got wr=%b add=%h data=%h want 1/00001000/aa", bus_wr, bus_add, bus_data); end
    step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h1001, 8'hBB})
      begin miscompares++; $display("FAIL basic_w1: got wr=%b add=%h data=%h want 1/00001001/bb", bus_wr, bus_add, bus_data); end
    vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL basic_active_end: got %b want 0", active); end
    step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b0, 32'h1001, 8'hBB})
      begin miscompares++; $display("FAIL basic_hold: got wr=%b add=%h data=%h want 0/00001001/bb", bus_wr, bus_add, bus_data); end
    idle(1);
    vectors++; if (wr_count - base !== 2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", wr_count - base); end
  endtask

  task automatic test_header_only;
    base = wr_count;
    step(1, HEADER_BYTES[7:0], 1); step(1, 8'h00, 1);
    step(1, 8'h20, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h07, 1);
    vectors++; if ({active, bus_wr} !== 2'b00) begin miscompares++; $display("FAIL hdr_only_idle: got active=%b wr=%b want 0/0", active, bus_wr); end
    step(1, 8'h00, 1); step(1, 8'h40, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h55, 1); step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h40, 8'h55})
      begin miscompares++; $display("FAIL hdr_only_next: got wr=%b add=%h data=%h want 1/00000040/55", bus_wr, bus_add, bus_data); end
    idle(2);
    vectors++; if (wr_count - base !== 1) begin miscompares++; $display("FAIL hdr_only_count: got %0d want 1", wr_count - base); end
  endtask

  task automatic test_wrap;
    step(1, 8'h08, 1); step(1, 8'h00, 1);
    step(1, 8'hFF, 1); step(1, 8'hFF, 1); step(1, 8'hFF, 1); step(1, 8'hFF, 1);
    step(1, 8'h11, 1); step(1, 8'h22, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'hFFFF_FFFF, 8'h11})
      begin miscompares++; $display("FAIL wrap_w0: got wr=%b add=%h data=%h want 1/ffffffff/11", bus_wr, bus_add, bus_data); end
    step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h0, 8'h22})
      begin miscompares++; $display("FAIL wrap_w1: got wr=%b add=%h data=%h want 1/00000000/22", bus_wr, bus_add, bus_data); end
    idle(2);
  endtask

  task automatic test_error;
    base = wr_count;
    step(1, 8'h03, 1); step(1, 8'h00, 1);
    step(1, 8'h00, 1); step(1, 8'h01, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'hAB, 1);
    vectors++; if ({error, active} !== 2'b11) begin miscompares++; $display("FAIL err_set: got error=%b active=%b want 1/1", error, active); end
    vectors++; if (dut.r_state !== ST_ERR) begin miscompares++; $display("FAIL err_state: got %0d want %0d", dut.r_state, ST_ERR); end
    step(1, 8'h01, 1); step(1, 8'h02, 1); step(1, 8'h03, 1);
    idle(2);
    vectors++; if (wr_count - base !== 0) begin miscompares++; $display("FAIL err_nowrite: got %0d want 0", wr_count - base); end
    step(0, 8'h00, 0); step(0, 8'h00, 1);
    vectors++; if ({active, error} !== 2'b01) begin miscompares++; $display("FAIL err_drop: got active=%b error=%b want 0/1", active, error); end
    step(1, 8'h07, 1); step(1, 8'h00, 1);
    step(1, 8'h30, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h99, 1); step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data, error} !== {1'b1, 32'h30, 8'h99, 1'b1})
      begin miscompares++; $display("FAIL err_recover: got wr=%b add=%h data=%h err=%b want 1/00000030/99/1", bus_wr, bus_add, bus_data, error); end
    idle(2);
  endtask

  task automatic test_abort;
    base = wr_count;
    step(1, 8'h0A, 1); step(1, 8'h00, 1);
    step(1, 8'h00, 1); step(1, 8'h02, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'hD0, 1); step(1, 8'hD1, 1);
    step(1, 8'hD2, 0);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h201, 8'hD1})
      begin miscompares++; $display("FAIL abort_w1: got wr=%b add=%h data=%h want 1/00000201/d1", bus_wr, bus_add, bus_data); end
    step(0, 8'h00, 1);
    vectors++; if ({bus_wr, active} !== 2'b00) begin miscompares++; $display("FAIL abort_idle: got wr=%b active=%b want 0/0", bus_wr, active); end
    idle(1);
    vectors++; if (wr_count - base !== 2) begin miscompares++; $display("FAIL abort_count: got %0d want 2", wr_count - base); end
    step(1, 8'h07, 1); step(1, 8'h00, 1);
    step(1, 8'h50, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h77, 1); step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h50, 8'h77})
      begin miscompares++; $display("FAIL abort_reconnect: got wr=%b add=%h data=%h want 1/00000050/77", bus_wr, bus_add, bus_data); end
    idle(2);
  endtask

  task automatic test_reset_mid;
    base = wr_count;
    step(1, 8'h0A, 1); step(1, 8'h00, 1);
    step(1, 8'h60, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'hE0, 1); step(1, 8'hE1, 1);
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus_wr, bus_add, bus_data, active, error} !== {1'b0, 32'h0, 8'h00, 1'b0, 1'b0})
      begin miscompares++; $display("FAIL rstmid_out: got wr=%b add=%h data=%h act=%b err=%b want all 0", bus_wr, bus_add, bus_data, active, error); end
    rx_wr = 1'b0;
    idle(3);
    vectors++; if (wr_count - base !== 1) begin miscompares++; $display("FAIL rstmid_count: got %0d want 1", wr_count - base); end
    rst_n = 1'b1;
    step(1, 8'h07, 1); step(1, 8'h00, 1);
    step(1, 8'h70, 1); step(1, 8'h00, 1); step(1, 8'h00, 1); step(1, 8'h00, 1);
    step(1, 8'h5A, 1); step(0, 8'h00, 1);
    vectors++; if ({bus_wr, bus_add, bus_data} !== {1'b1, 32'h70, 8'h5A})
      begin miscompares++; $display("FAIL rstmid_fresh: got wr=%b add=%h data=%h want 1/00000070/5a", bus_wr, bus_add, bus_data); end
    idle(2);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_header_only;
    test_wrap;
    test_error;
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
